move_arbiter: RTL and testbench
===============================

# move_arbiter

Sequences all piece-movement commands into the single shared move engine of the 8x8 LED Tetris core. Four single-cycle button requests (left, right, rotate, soft-drop) and an internally generated, level-dependent gravity tick compete for the engine. The arbiter latches requests, grants them by fixed priority, and issues one command at a time over a valid/ready handshake. It then waits for the engine's done pulse before granting again, so no request is lost while the engine is busy.

## Interface
- DIV_WIDTH, 10: width of the gravity tick counter.
- PERIOD_BASE, 480: gravity period in `tick` pulses at level 0.
- PERIOD_STEP, 60: period reduction per level.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  game running; low clears all pending state.
- tick  in  1  timebase strobe, one cycle wide.
- level  in  3  difficulty level, 0..7.
- btn_left, btn_right, btn_rot, btn_down  in  1 each  debounced one-cycle request pulses.
- cmd_valid  out  1  command offered to the engine.
- cmd  out  3  command code: 0 none, 1 GRAVITY, 2 DOWN, 3 ROTATE, 4 LEFT, 5 RIGHT.
- cmd_ready  in  1  engine accepts the offered command.
- done  in  1  one-cycle pulse from the engine when the move completes.
- overrun  out  1  one-cycle pulse when a gravity tick fires while gravity is already pending.

## Operation
- Pending flags: one flag per source (grav, down, rot, left, right).
  - A request input sets its flag on the clock edge it is sampled high.
  - A repeat request while the flag is set coalesces.
- Priority, highest first: GRAVITY > DOWN > ROTATE > LEFT > RIGHT.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any flag is set, load `cmd` with the highest-priority source, clear that flag, and go to ISSUE.
  - ISSUE: `cmd_valid`=1 and `cmd` is held stable. On an edge with `cmd_ready`=1, go to WAIT; `cmd_valid`=0 and `cmd`=0.
  - WAIT: on an edge with `done`=1, go to IDLE. `done` is ignored outside WAIT.
- Set wins over clear: a request arriving on the same edge its flag is granted leaves the flag set.
- Gravity period P = PERIOD_BASE − level·PERIOD_STEP, computed at DIV_WIDTH+3 bits and clamped to a minimum of 1.
- Gravity counter:
  - Increments on each edge where `enable` and `tick` are both 1.
  - On a tick where count ≥ P−1, count←0 and the grav flag is set; if grav was already set, `overrun` pulses for one cycle.
  - The ≥ comparison makes a level increase mid-period fire on the next tick.
- `enable`=0:
  - Clears all five flags and the gravity counter.
  - From IDLE, the FSM stays in IDLE.
  - A command already in ISSUE or WAIT completes normally; no new grants are made while disabled.

## Timing
- Reset values:
  - state IDLE, all flags 0, counter 0;
  - `cmd_valid`=0, `cmd`=0, `overrun`=0.
- Reset mid-operation abandons any offered or in-flight command immediately. The engine is reset by the same signal.
- Latency:
  - A request sampled at edge k gives a flag set after edge k.
  - The grant occurs at edge k+1, so `cmd_valid`=1 in the cycle after edge k+1.
- Ready already high: if `cmd_ready` is high when `cmd_valid` rises, the handshake completes at the next edge and `cmd_valid` is high for exactly one cycle.
- Back-to-back: `done` at edge d → IDLE; the next grant is at edge d+1. The minimum command spacing is 3 cycles with ready and done both immediate.
- All outputs are registered; no combinational path exists from inputs to outputs.

## Test plan
- Reset, then `btn_left` pulse at edge 2 → `cmd_valid`=1, `cmd`=4 after edge 3; `cmd_ready`=1 → `cmd_valid` falls at edge 4; `done` at edge 6 → IDLE.
- With the FSM in WAIT, pulse `btn_right`, `btn_rot`, `btn_down` and force a gravity tick → after `done`, the grant order is 1, 2, 3, 5, one per cycle of handshaking.
- Parameters BASE=4, STEP=1, level=0, `tick` every cycle, engine idle → GRAVITY issued every 4 ticks. Switch to level=3 with count=2 → fires on the next tick, then every tick (P=1).
- Hold `cmd_ready`=0 and `done`=0 with gravity firing twice → one `overrun` pulse and a single GRAVITY pending.
- Pulse `btn_rot` on the same edge ROTATE is granted → a second ROTATE is issued after the first `done`.
- Assert reset while in WAIT with flags pending → next cycle `cmd_valid`=0, `cmd`=0, no grants until a new request; drop `enable` → pending flags are discarded.

Source files
------------

// File: rtl/move_arbiter_if.sv
// ============================================================================
// Module  : move_arbiter_if
// Brief   : Command handshake between the move arbiter and the move engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface move_arbiter_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic       done;

    modport master (output cmd_valid, output cmd, input cmd_ready, input done);
    modport slave  (input cmd_valid, input cmd, output cmd_ready, output done);
endinterface

`default_nettype wire

// File: rtl/move_arbiter.sv
// ============================================================================
// Module  : move_arbiter
// Brief   : Latches button/gravity requests and issues them one at a time,
//           by fixed priority, to the shared Tetris move engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module move_arbiter #(
    parameter int DIV_WIDTH   = 10,
    parameter int PERIOD_BASE = 480,
    parameter int PERIOD_STEP = 60
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       enable,
    input  wire logic       tick,
    input  wire logic [2:0] level,
    input  wire logic       btn_left,
    input  wire logic       btn_right,
    input  wire logic       btn_rot,
    input  wire logic       btn_down,
    move_arbiter_if.master  eng,
    output logic            overrun
);

    localparam int c_PW = DIV_WIDTH + 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t               r_state;
    logic [4:0]           r_pend;      // index = priority: grav, down, rot, left, right
    logic [DIV_WIDTH-1:0] r_count;
    logic                 r_cmd_valid;
    logic [2:0]           r_cmd;
    logic                 r_overrun;

    logic [c_PW-1:0] w_sub;
    logic [c_PW-1:0] w_period;
    logic            w_fire;
    logic [4:0]      w_req;
    logic [4:0]      w_grant_oh;
    logic [2:0]      w_grant_cmd;
    logic            w_do_grant;

    // Clamp instead of wrapping when the level reduction exceeds the base period
    assign w_sub    = c_PW'(level) * c_PW'(PERIOD_STEP);
    assign w_period = (w_sub >= c_PW'(PERIOD_BASE)) ? c_PW'(1) : c_PW'(PERIOD_BASE) - w_sub;
    assign w_fire   = enable & tick & ({3'b000, r_count} >= (w_period - c_PW'(1)));

    assign w_req      = {btn_right, btn_left, btn_rot, btn_down, w_fire};
    assign w_do_grant = (r_state == S_IDLE) && enable && (|r_pend);

    always_comb begin
        w_grant_oh  = 5'b00000;
        w_grant_cmd = 3'd0;
        if (r_pend[0]) begin
            w_grant_oh = 5'b00001; w_grant_cmd = 3'd1;
        end else if (r_pend[1]) begin
            w_grant_oh = 5'b00010; w_grant_cmd = 3'd2;
        end else if (r_pend[2]) begin
            w_grant_oh = 5'b00100; w_grant_cmd = 3'd3;
        end else if (r_pend[3]) begin
            w_grant_oh = 5'b01000; w_grant_cmd = 3'd4;
        end else if (r_pend[4]) begin
            w_grant_oh = 5'b10000; w_grant_cmd = 3'd5;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pend      <= '0;
            r_count     <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= 3'd0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= w_fire & r_pend[0];

            // A request on the grant edge re-arms its flag (set wins over clear)
            if (!enable) begin
                r_pend  <= '0;
                r_count <= '0;
            end else begin
                r_pend <= (r_pend & ~(w_do_grant ? w_grant_oh : 5'b00000)) | w_req;
                if (tick)
                    r_count <= w_fire ? '0 : r_count + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_do_grant) begin
                        r_cmd       <= w_grant_cmd;
                        r_cmd_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (eng.cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cmd       <= 3'd0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (eng.done)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_valid <= 1'b0;
                    r_cmd       <= 3'd0;
                end
            endcase
        end
    end

    assign eng.cmd_valid = r_cmd_valid;
    assign eng.cmd       = r_cmd;
    assign overrun       = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_move_arbiter.sv
// ============================================================================
// Module  : tb_move_arbiter
// Brief   : Self-checking bench for move_arbiter against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_move_arbiter;

    localparam int BASE = 4;
    localparam int STEP = 1;

    logic       clk = 1'b0;
    logic       reset, enable, tick;
    logic [2:0] level;
    logic       btn_left, btn_right, btn_rot, btn_down;
    logic       overrun;

    move_arbiter_if eng ();

    move_arbiter #(.DIV_WIDTH(4), .PERIOD_BASE(BASE), .PERIOD_STEP(STEP)) dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick), .level(level),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot),
        .btn_down(btn_down), .eng(eng.master), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: pending requests by priority rank, engine phase
    bit m_pend[5];
    int m_cnt, m_phase, m_valid, m_cmd, m_ovr;
    bit prev_valid;
    int seen[$];
    int ovr_seen;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        if (obs !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        int  p, g;
        bit  fire;
        if (reset) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_cnt = 0; m_phase = 0; m_valid = 0; m_cmd = 0; m_ovr = 0;
        end else begin
            p = BASE - int'(level) * STEP;
            if (p < 1) p = 1;
            fire  = enable && tick && (m_cnt >= p - 1);
            m_ovr = int'(fire && m_pend[0]);
            g = -1;
            case (m_phase)
                0: begin
                    if (enable)
                        for (int i = 0; i < 5; i++)
                            if (g < 0 && m_pend[i]) g = i;
                    if (g >= 0) begin m_phase = 1; m_valid = 1; m_cmd = g + 1; end
                end
                1: if (eng.cmd_ready) begin m_phase = 2; m_valid = 0; m_cmd = 0; end
                default: if (eng.done) m_phase = 0;
            endcase
            if (!enable) begin
                foreach (m_pend[i]) m_pend[i] = 0;
                m_cnt = 0;
            end else begin
                if (g >= 0) m_pend[g] = 0;
                m_pend[0] |= fire;
                m_pend[1] |= btn_down;
                m_pend[2] |= btn_rot;
                m_pend[3] |= btn_left;
                m_pend[4] |= btn_right;
                if (tick) m_cnt = fire ? 0 : m_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
        check("cmd_valid", eng.cmd_valid, m_valid);
        check("cmd", eng.cmd, m_cmd);
        check("overrun", overrun, m_ovr);
        if (eng.cmd_valid && !prev_valid) seen.push_back(int'(eng.cmd));
        prev_valid = eng.cmd_valid;
        if (overrun) ovr_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_left();
        btn_left = 1'b1; step(); btn_left = 1'b0;
    endtask

    initial begin
        int exp_order[4];
        exp_order[0] = 1; exp_order[1] = 2; exp_order[2] = 3; exp_order[3] = 5;
        reset = 1'b1; enable = 1'b1; tick = 1'b0; level = 3'd0;
        btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0; btn_down = 1'b0;
        eng.cmd_ready = 1'b0; eng.done = 1'b0;
        prev_valid = 1'b0; ovr_seen = 0;
        run(2);
        check("rst_valid", eng.cmd_valid, 0);
        check("rst_cmd", eng.cmd, 0);
        reset = 1'b0;

        // Single LEFT request through the full handshake
        pulse_left();
        step();
        check("left_cmd", eng.cmd, 4);
        eng.cmd_ready = 1'b1; step(); eng.cmd_ready = 1'b0;
        check("left_valid_fall", eng.cmd_valid, 0);
        step();
        eng.done = 1'b1; step(); eng.done = 1'b0;

        // Requests collected while busy come out in priority order
        pulse_left(); step();
        eng.cmd_ready = 1'b1; step(); eng.cmd_ready = 1'b0;
        btn_right = 1'b1; btn_rot = 1'b1; btn_down = 1'b1; tick = 1'b1; level = 3'd7;
        step();
        btn_right = 1'b0; btn_rot = 1'b0; btn_down = 1'b0; tick = 1'b0; level = 3'd0;
        seen.delete();
        eng.cmd_ready = 1'b1; eng.done = 1'b1;
        run(14);
        check("order_n", seen.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < seen.size()) check("order", seen[i], exp_order[i]);

        // Gravity every 4 ticks at level 0
        enable = 1'b0; step(); enable = 1'b1;
        seen.delete();
        tick = 1'b1; run(16); tick = 1'b0; run(2);
        check("grav_n", seen.size(), 4);
        foreach (seen[i]) check("grav_cmd", seen[i], 1);

        // Level raise mid-period fires on the next tick, then every tick
        tick = 1'b1; run(2);
        level = 3'd3; step();
        step();
        check("lvl_fire_valid", eng.cmd_valid, 1);
        check("lvl_fire_cmd", eng.cmd, 1);
        run(10);
        tick = 1'b0; level = 3'd0;
        run(20);

        // Two gravity fires while stalled: one overrun, one GRAVITY pending
        eng.cmd_ready = 1'b0; eng.done = 1'b0;
        pulse_left(); step();
        ovr_seen = 0;
        level = 3'd7; tick = 1'b1; run(2); tick = 1'b0; level = 3'd0;
        step();
        check("ovr_n", ovr_seen, 1);
        seen.delete();
        eng.cmd_ready = 1'b1; eng.done = 1'b1;
        run(10);
        check("ovr_grav_n", seen.size(), 1);
        if (seen.size() > 0) check("ovr_grav_cmd", seen[0], 1);

        // ROTATE re-requested on its grant edge is issued twice
        eng.cmd_ready = 1'b0; eng.done = 1'b0;
        seen.delete();
        btn_rot = 1'b1; run(2); btn_rot = 1'b0;
        eng.cmd_ready = 1'b1; eng.done = 1'b1;
        run(10);
        check("rot_n", seen.size(), 2);
        foreach (seen[i]) check("rot_cmd", seen[i], 3);

        // Reset in WAIT with a pending flag discards everything
        eng.done = 1'b0;
        pulse_left(); run(2);
        btn_right = 1'b1; step(); btn_right = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        check("rst_mid_valid", eng.cmd_valid, 0);
        check("rst_mid_cmd", eng.cmd, 0);
        seen.delete();
        eng.done = 1'b1;
        run(6);
        check("rst_mid_grants", seen.size(), 0);
        btn_down = 1'b1; step(); btn_down = 1'b0;
        enable = 1'b0; step(); enable = 1'b1;
        run(6);
        check("dis_grants", seen.size(), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom % 256) == 0;
            enable        = ($urandom % 32) != 0;
            tick          = ($urandom % 3) == 0;
            if (($urandom % 50) == 0) level = 3'($urandom_range(0, 7));
            btn_left      = ($urandom % 6) == 0;
            btn_right     = ($urandom % 6) == 0;
            btn_rot       = ($urandom % 6) == 0;
            btn_down      = ($urandom % 6) == 0;
            eng.cmd_ready = ($urandom % 2) == 0;
            eng.done      = ($urandom % 3) == 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
